// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares two registered writeback/wakeup broadcast ports
// between NUM_REQ execution-unit result sources using a round-robin scan.
//
// Handshake: requester i presents req_valid[i] with a stable payload. A
// transfer happens in a cycle where req_valid[i] & req_ready[i]. req_ready
// is combinational from req_valid, the round-robin pointer and flush.
// req_valid must not depend on req_ready. The consumer side has no
// backpressure. A granted result appears on wb_* one cycle later.
//
// Optional build macro WB_ARB_PERF_EN adds perf_stall_cnt. This output has
// one saturating 16-bit stall counter per requester.
//
// Debug: the round-robin pointer is kept in rr_ptr_q, and that flop is
// also driven onto the dbg_rr_ptr output.
module wb_port_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WB_PORTS = 2,
  parameter int PHYS_W   = 6,
  parameter int ROB_W    = 4,
  parameter int BANK_W   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*PHYS_W-1:0]    req_phys_rd,
  input  logic [NUM_REQ*32-1:0]        req_data,
  input  logic [NUM_REQ*ROB_W-1:0]     req_rob_addr,
  input  logic [NUM_REQ*BANK_W-1:0]    req_bank_addr,
  output logic [WB_PORTS-1:0]          wb_valid,
  output logic [WB_PORTS*PHYS_W-1:0]   wb_phys_rd,
  output logic [WB_PORTS*32-1:0]       wb_data,
  output logic [WB_PORTS*ROB_W-1:0]    wb_rob_addr,
  output logic [WB_PORTS*BANK_W-1:0]   wb_bank_addr,
`ifdef WB_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0]        perf_stall_cnt,
`endif
  output logic [$clog2(NUM_REQ)-1:0]   dbg_rr_ptr
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int PW1   = PTR_W + 1;
  localparam logic [PTR_W:0] NUM_REQ_W = PW1'(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             g0_found, g1_found;
  logic [PTR_W-1:0] g0_idx, g1_idx;
  logic [PTR_W:0]   scan_wide;
  logic [PTR_W-1:0] scan_idx;

  logic [PTR_W-1:0] last_idx;
  logic [PTR_W:0]   nxt_wide;

  logic [PHYS_W-1:0] sel0_phys, sel1_phys;
  logic [31:0]       sel0_data, sel1_data;
  logic [ROB_W-1:0]  sel0_rob, sel1_rob;
  logic [BANK_W-1:0] sel0_bank, sel1_bank;

  logic [1:0]        wb_valid_q, wb_valid_d;
  logic [PHYS_W-1:0] wb_phys_q [2];
  logic [PHYS_W-1:0] wb_phys_d [2];
  logic [31:0]       wb_data_q [2];
  logic [31:0]       wb_data_d [2];
  logic [ROB_W-1:0]  wb_rob_q  [2];
  logic [ROB_W-1:0]  wb_rob_d  [2];
  logic [BANK_W-1:0] wb_bank_q [2];
  logic [BANK_W-1:0] wb_bank_d [2];

  // Round-robin scan from rr_ptr_q: the first two valid requesters get grants.
  // Flush suppresses every grant.
  always_comb begin
    g0_found  = 1'b0;
    g1_found  = 1'b0;
    g0_idx    = '0;
    g1_idx    = '0;
    req_ready = '0;
    scan_wide = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Wrap by compare-and-subtract at PTR_W+1 bits. This stays correct
      // when NUM_REQ is not a power of two.
      scan_wide = PW1'(rr_ptr_q) + PW1'(k);
      if (scan_wide >= NUM_REQ_W) begin
        scan_wide = scan_wide - NUM_REQ_W;
      end
      scan_idx = scan_wide[PTR_W-1:0];
      if (!flush && req_valid[scan_idx] && !g1_found) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = scan_idx;
        end else begin
          g1_found = 1'b1;
          g1_idx   = scan_idx;
        end
        req_ready[scan_idx] = 1'b1;
      end
    end
  end

  // The pointer moves to the slot after the last granted requester.
  // It does not move when there is no grant.
  always_comb begin
    last_idx = g1_found ? g1_idx : g0_idx;
    nxt_wide = PW1'(last_idx) + PW1'(1);
    rr_ptr_d = rr_ptr_q;
    if (g0_found) begin
      if (nxt_wide == NUM_REQ_W) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = nxt_wide[PTR_W-1:0];
      end
    end
  end

  // Payload multiplexers that select the granted requester slice for each port.
  always_comb begin
    sel0_phys = '0;
    sel0_data = '0;
    sel0_rob  = '0;
    sel0_bank = '0;
    sel1_phys = '0;
    sel1_data = '0;
    sel1_rob  = '0;
    sel1_bank = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g0_idx == PTR_W'(i)) begin
        sel0_phys = req_phys_rd[i*PHYS_W +: PHYS_W];
        sel0_data = req_data[i*32 +: 32];
        sel0_rob  = req_rob_addr[i*ROB_W +: ROB_W];
        sel0_bank = req_bank_addr[i*BANK_W +: BANK_W];
      end
      if (g1_idx == PTR_W'(i)) begin
        sel1_phys = req_phys_rd[i*PHYS_W +: PHYS_W];
        sel1_data = req_data[i*32 +: 32];
        sel1_rob  = req_rob_addr[i*ROB_W +: ROB_W];
        sel1_bank = req_bank_addr[i*BANK_W +: BANK_W];
      end
    end
  end

  // Next broadcast state. A port with no grant keeps its old payload.
  always_comb begin
    wb_valid_d   = {g1_found, g0_found};
    wb_phys_d[0] = g0_found ? sel0_phys : wb_phys_q[0];
    wb_data_d[0] = g0_found ? sel0_data : wb_data_q[0];
    wb_rob_d[0]  = g0_found ? sel0_rob  : wb_rob_q[0];
    wb_bank_d[0] = g0_found ? sel0_bank : wb_bank_q[0];
    wb_phys_d[1] = g1_found ? sel1_phys : wb_phys_q[1];
    wb_data_d[1] = g1_found ? sel1_data : wb_data_q[1];
    wb_rob_d[1]  = g1_found ? sel1_rob  : wb_rob_q[1];
    wb_bank_d[1] = g1_found ? sel1_bank : wb_bank_q[1];
  end

  // Pointer and broadcast registers. Reset has priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= '0;
      for (int p = 0; p < 2; p++) begin
        wb_phys_q[p] <= '0;
        wb_data_q[p] <= '0;
        wb_rob_q[p]  <= '0;
        wb_bank_q[p] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      for (int p = 0; p < 2; p++) begin
        wb_phys_q[p] <= wb_phys_d[p];
        wb_data_q[p] <= wb_data_d[p];
        wb_rob_q[p]  <= wb_rob_d[p];
        wb_bank_q[p] <= wb_bank_d[p];
      end
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_phys_rd   = {wb_phys_q[1], wb_phys_q[0]};
  assign wb_data      = {wb_data_q[1], wb_data_q[0]};
  assign wb_rob_addr  = {wb_rob_q[1],  wb_rob_q[0]};
  assign wb_bank_addr = {wb_bank_q[1], wb_bank_q[0]};
  assign dbg_rr_ptr   = rr_ptr_q;

`ifdef WB_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] stall_cnt_q, stall_cnt_d;

  // Saturating per-requester stall counters. Flush cycles also count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !req_ready[i] && (stall_cnt_q[i] != 16'hFFFF)) begin
        stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
      end
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed test for wb_port_arbiter with NUM_REQ=4.
// Inputs change 1ns after the rising edge. Checks also run 1ns after the edge.
module tb_wb_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int PHYS_W  = 6;
  localparam int ROB_W   = 4;
  localparam int BANK_W  = 1;

  logic                        clk;
  logic                        rst;
  logic                        flush;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*PHYS_W-1:0]   req_phys_rd;
  logic [NUM_REQ*32-1:0]       req_data;
  logic [NUM_REQ*ROB_W-1:0]    req_rob_addr;
  logic [NUM_REQ*BANK_W-1:0]   req_bank_addr;
  logic [1:0]                  wb_valid;
  logic [2*PHYS_W-1:0]         wb_phys_rd;
  logic [2*32-1:0]             wb_data;
  logic [2*ROB_W-1:0]          wb_rob_addr;
  logic [2*BANK_W-1:0]         wb_bank_addr;
  logic [1:0]                  dbg_rr_ptr;
`ifdef WB_ARB_PERF_EN
  logic [NUM_REQ*16-1:0]       perf_stall_cnt;
`endif

  int assert_cnt = 0;
  int fail_cnt   = 0;

  wb_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WB_PORTS(2),
    .PHYS_W  (PHYS_W),
    .ROB_W   (ROB_W),
    .BANK_W  (BANK_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_phys_rd  (req_phys_rd),
    .req_data     (req_data),
    .req_rob_addr (req_rob_addr),
    .req_bank_addr(req_bank_addr),
    .wb_valid     (wb_valid),
    .wb_phys_rd   (wb_phys_rd),
    .wb_data      (wb_data),
    .wb_rob_addr  (wb_rob_addr),
`ifdef WB_ARB_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .wb_bank_addr (wb_bank_addr),
    .dbg_rr_ptr   (dbg_rr_ptr)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle. The new values can be read after this returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [PHYS_W-1:0] phys, input logic [31:0] data,
                         input logic [ROB_W-1:0] rob, input logic [BANK_W-1:0] bank);
    req_phys_rd[i*PHYS_W +: PHYS_W]   = phys;
    req_data[i*32 +: 32]              = data;
    req_rob_addr[i*ROB_W +: ROB_W]    = rob;
    req_bank_addr[i*BANK_W +: BANK_W] = bank;
  endtask

  task automatic check_port(input string tag, input int p, input logic [PHYS_W-1:0] phys,
                            input logic [31:0] data);
    check({tag, "_phys"}, 64'(wb_phys_rd[p*PHYS_W +: PHYS_W]), 64'(phys));
    check({tag, "_data"}, 64'(wb_data[p*32 +: 32]), 64'(data));
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    req_valid     = '0;
    req_phys_rd   = '0;
    req_data      = '0;
    req_rob_addr  = '0;
    req_bank_addr = '0;

    // Reset and idle.
    step();
    step();
    check("reset_wb_valid", 64'(wb_valid), 64'h0);
    check("reset_rr_ptr", 64'(dbg_rr_ptr), 64'h0);
    check("reset_wb_data", 64'(wb_data), 64'h0);
    check("reset_wb_phys", 64'(wb_phys_rd), 64'h0);
    rst = 1'b0;
    step();
    check("idle_ready", 64'(req_ready), 64'h0);
    check("idle_wb_valid", 64'(wb_valid), 64'h0);

    // Single request from requester 0.
    set_req(0, 6'd5, 32'hDEAD_BEEF, 4'd9, 1'b1);
    req_valid = 4'b0001;
    #1;
    check("single_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b0000;
    check("single_wb_valid", 64'(wb_valid), 64'h1);
    check_port("single_p0", 0, 6'd5, 32'hDEAD_BEEF);
    check("single_rob", 64'(wb_rob_addr[3:0]), 64'h9);
    check("single_bank", 64'(wb_bank_addr[0]), 64'h1);
    check("single_rr_ptr", 64'(dbg_rr_ptr), 64'h1);

    // Distinct payloads: phys = 10+i, data = A000_0000+i, rob = 4+i.
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, PHYS_W'(10 + i), 32'hA000_0000 + 32'(i), ROB_W'(4 + i), BANK_W'(i));
    end

    // Requester 3 alone. The pointer moves from 1 to 0.
    req_valid = 4'b1000;
    #1;
    check("r3_ready", 64'(req_ready), 64'h8);
    step();
    req_valid = 4'b0000;
    check("r3_wb_valid", 64'(wb_valid), 64'h1);
    check_port("r3_p0", 0, 6'd13, 32'hA000_0003);
    check("r3_rr_ptr", 64'(dbg_rr_ptr), 64'h0);

    // All four requesters are held for four cycles.
    req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #0;
      check("all_ready", 64'(req_ready), (c % 2 == 0) ? 64'h3 : 64'hC);
      step();
      check("all_wb_valid", 64'(wb_valid), 64'h3);
      check_port("all_p0", 0, PHYS_W'((c % 2 == 0) ? 10 : 12),
                 32'hA000_0000 + 32'((c % 2 == 0) ? 0 : 2));
      check_port("all_p1", 1, PHYS_W'((c % 2 == 0) ? 11 : 13),
                 32'hA000_0000 + 32'((c % 2 == 0) ? 1 : 3));
      check("all_rr_ptr", 64'(dbg_rr_ptr), (c % 2 == 0) ? 64'h2 : 64'h0);
    end
    req_valid = 4'b0000;

    // Move the pointer to 3 with a grant to requester 2.
    req_valid = 4'b0100;
    step();
    check("to3_rr_ptr", 64'(dbg_rr_ptr), 64'h3);
    check_port("to3_p0", 0, 6'd12, 32'hA000_0002);

    // Wrapped pair: port 0 carries requester 3 and port 1 carries requester 0.
    req_valid = 4'b1001;
    #1;
    check("wrap_ready", 64'(req_ready), 64'h9);
    step();
    req_valid = 4'b0000;
    check("wrap_wb_valid", 64'(wb_valid), 64'h3);
    check_port("wrap_p0", 0, 6'd13, 32'hA000_0003);
    check_port("wrap_p1", 1, 6'd10, 32'hA000_0000);
    check("wrap_rob", 64'(wb_rob_addr), 64'({4'd4, 4'd7}));
    check("wrap_rr_ptr", 64'(dbg_rr_ptr), 64'h1);

    // Flush blocks all grants. Results already on wb are still visible.
    req_valid = 4'b0110;
    flush     = 1'b1;
    #1;
    check("flush_ready", 64'(req_ready), 64'h0);
    check("flush_prev_visible", 64'(wb_valid), 64'h3);
    step();
    flush = 1'b0;
    check("flush_wb_valid", 64'(wb_valid), 64'h0);
    check("flush_rr_ptr", 64'(dbg_rr_ptr), 64'h1);
    #1;
    check("post_flush_ready", 64'(req_ready), 64'h6);
    step();
    req_valid = 4'b0000;
    check("post_flush_wb_valid", 64'(wb_valid), 64'h3);
    check_port("post_flush_p0", 0, 6'd11, 32'hA000_0001);
    check_port("post_flush_p1", 1, 6'd12, 32'hA000_0002);
    check("post_flush_rr_ptr", 64'(dbg_rr_ptr), 64'h3);

    // One grant while the pointer is 3. The grant is packed onto port 0.
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    check("pack_wb_valid", 64'(wb_valid), 64'h1);
    check_port("pack_p0", 0, 6'd11, 32'hA000_0001);
    check("pack_rr_ptr", 64'(dbg_rr_ptr), 64'h2);

    // Reset in mid-operation, asserted together with flush. Reset wins.
    req_valid = 4'b1111;
    #1;
    check("prerst_ready", 64'(req_ready), 64'hC);
    rst   = 1'b1;
    flush = 1'b1;
    step();
    check("midrst_wb_valid", 64'(wb_valid), 64'h0);
    check("midrst_rr_ptr", 64'(dbg_rr_ptr), 64'h0);
    check("midrst_wb_phys", 64'(wb_phys_rd), 64'h0);
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b0000;
    step();
    check("after_rst_wb_valid", 64'(wb_valid), 64'h0);

`ifdef WB_ARB_PERF_EN
    // All four requesters for ten cycles. Each one stalls for five cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("perf_reset", 64'(perf_stall_cnt), 64'h0);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) step();
    req_valid = 4'b0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      check("perf_cnt5", 64'(perf_stall_cnt[i*16 +: 16]), 64'h5);
    end
    // A counter at FFFF saturates and stays at FFFF.
    force dut.stall_cnt_q = {NUM_REQ{16'hFFFF}};
    #1;
    release dut.stall_cnt_q;
    req_valid = 4'b1111;
    step();
    step();
    req_valid = 4'b0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      check("perf_sat", 64'(perf_stall_cnt[i*16 +: 16]), 64'hFFFF);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the two writeback/wakeup broadcast ports between NUM_REQ execution-unit result sources (ALU0, ALU1, MUL/DIV, LSU, ...).
- Downstream consumers are the issue-queue wakeup interface and the physical register file write port.
- Uses a round-robin scheduler with a valid/ready handshake on the requester side.
- Outputs are registered, giving 1-cycle latency from grant to broadcast.

Parameters:
- NUM_REQ, 4, number of result requesters (2..8).
- WB_PORTS, 2, number of writeback broadcast ports (fixed at 2; other values unsupported).
- PHYS_W, 6, physical register address width.
- ROB_W, 4, ROB index width.
- BANK_W, 1, dispatch bank address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush; drops all grants this cycle
- req_valid  in  NUM_REQ  requester i has a result
- req_ready  out  NUM_REQ  requester i granted this cycle (combinational)
- req_phys_rd  in  NUM_REQ*PHYS_W  destination phys reg, slice i
- req_data  in  NUM_REQ*32  result data, slice i
- req_rob_addr  in  NUM_REQ*ROB_W  ROB index, slice i
- req_bank_addr  in  NUM_REQ*BANK_W  dispatch bank, slice i
- wb_valid  out  2  broadcast port p valid
- wb_phys_rd  out  2*PHYS_W  port p phys reg
- wb_data  out  2*32  port p data
- wb_rob_addr  out  2*ROB_W  port p ROB index
- wb_bank_addr  out  2*BANK_W  port p bank

Behaviour:
- Reset state: rr_ptr=0; all wb_* outputs 0; wb_valid=2'b00.
- req_ready is combinational from req_valid, rr_ptr and flush. Requesters must not make req_valid depend on req_ready.
- Requesters hold req_valid and the payload stable until the handshake completes. A transfer occurs when req_valid[i] & req_ready[i].
- Scan order each cycle: i = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - First valid requester found: granted, routed to port 0.
  - Second valid requester found: granted, routed to port 1.
  - At most 2 grants per cycle.
- Next cycle: wb_valid[p] <= grant on port p; wb payload <= granted requester's slice. Ports with no grant get wb_valid[p]=0; their payload may hold its old value.
- Port 1 is never valid while port 0 is invalid (packed from port 0).
- rr_ptr update:
  - 0 grants: unchanged.
  - 1 or 2 grants: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - Wrap-around is explicit. When the increment equals NUM_REQ, the result is 0; arithmetic is done at $clog2(NUM_REQ)+1 bits and compared, not truncated.
- Fairness: any continuously asserted requester is granted within ceil(NUM_REQ/2) cycles.
- flush=1:
  - req_ready=0 for all requesters.
  - Next-cycle wb_valid=00.
  - rr_ptr unchanged.
  - Results already on wb_* in the flush cycle are not cancelled.
- Simultaneous flush and rst: rst wins.
- Reset asserted mid-operation: the next cycle shows reset values; pending requests are not remembered.
- No backpressure from consumers: the wb ports always accept.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt, NUM_REQ*16 bits.
  - Counter i increments each cycle req_valid[i] & !req_ready[i] (flush cycles included).
  - Counter saturates at 16'hFFFF and resets to 0 on rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan (NUM_REQ=4):
- Reset, then idle -> wb_valid=00, req_ready=0000, rr_ptr=0.
- req_valid=0001, phys_rd=5, data=32'hDEAD_BEEF -> req_ready=0001 same cycle. Next cycle wb_valid=01, wb_phys_rd[0]=5, wb_data[0]=DEAD_BEEF; rr_ptr=1.
- req_valid=1111 held for 4 cycles from rr_ptr=0:
  - grants per cycle are {0,1}, {2,3}, {0,1}, {2,3};
  - wb_valid=11 each following cycle, port0 carrying the lower scan-order index.
- rr_ptr=3, req_valid=1001 -> port0=req3, port1=req0 (wrap); rr_ptr becomes 1.
- req_valid=0110 with flush=1 -> req_ready=0000, next wb_valid=00, rr_ptr unchanged. Deassert flush -> grants {1,2}.
- WB_ARB_PERF_EN:
  - req_valid=1111 for 10 cycles -> each requester stalled 5 cycles, so each perf_stall_cnt slice reads 5.
  - Forcing a counter to 16'hFFFF and stalling again keeps it at FFFF.
